// File: rtl/ddr_frame_writer_pkg.sv
// Shared DDR controller defaults and pixel geometry for the frame writer.
package ddr_frame_writer_pkg;

    localparam int unsigned DDR_CTRL_ADDR_WIDTH = 28;
    localparam int unsigned DDR_DATA_WIDTH      = 256;
    localparam logic [DDR_CTRL_ADDR_WIDTH-1:0] DDR_MAX_ADDR = 28'h7FF_FFE0;

    localparam int unsigned PIX_W = 24;

endpackage

// File: rtl/ddr_wr_fifo.sv
// Synchronous first-word-fall-through word FIFO with an occupancy count.
module ddr_wr_fifo #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_push,
    input  logic [WIDTH-1:0]          i_push_data,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          o_head_c,
    output logic                      o_empty_c,
    output logic                      o_full_c,
    output logic [$clog2(DEPTH):0]    o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_empty_c = (r_level == '0);
    assign o_full_c  = (r_level == LVL_W'(DEPTH));
    assign o_head_c  = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    assign w_push_ok = i_push && (!o_full_c || i_pop);
    assign w_pop_ok  = i_pop && !o_empty_c;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/ddr_frame_writer.sv
// Packs 24-bit pixels into DDR words, buffers them, and issues single-beat
// write requests to the DDR controller with a wrapping frame address.
module ddr_frame_writer
    import ddr_frame_writer_pkg::*;
#(
    parameter int unsigned CTRL_ADDR_WIDTH = DDR_CTRL_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = DDR_DATA_WIDTH,
    parameter int unsigned PIX_PER_WORD    = 10,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned ADDR_STEP       = 32,
    parameter logic [CTRL_ADDR_WIDTH-1:0] MAX_ADDR = CTRL_ADDR_WIDTH'(DDR_MAX_ADDR)
) (
    input  logic                            ddr_clk,
    input  logic                            rstn,
    input  logic                            init_done,
    input  logic                            frame_start,
    input  logic                            pix_valid,
    input  logic [PIX_W-1:0]                pix_data,
    output logic                            pix_ready,
    output logic                            wr_req,
    output logic [CTRL_ADDR_WIDTH-1:0]      ddr_waddr,
    output logic [3:0]                      awlen,
    output logic [DATA_WIDTH-1:0]           ddr_wdata,
    input  logic                            wr_busy,
    input  logic                            wr_done,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int unsigned CNT_W = $clog2(PIX_PER_WORD);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    // Packer state
    logic [CNT_W-1:0]           r_cnt;
    logic [DATA_WIDTH-1:0]      r_word;
    logic                       r_push;
    logic [DATA_WIDTH-1:0]      r_push_data;
    logic                       r_active;

    logic                       w_accept;
    logic                       w_last;
    logic [CNT_W-1:0]           w_slot;
    logic [DATA_WIDTH-1:0]      w_word_ins;

    // Write engine state
    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic                       r_wr_req;
    logic [CTRL_ADDR_WIDTH-1:0] r_addr;
    logic [CTRL_ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic                       r_addr_rst_pend;

    logic                       w_enter_req;
    logic                       w_pop;
    logic                       w_addr_clr;
    logic [CTRL_ADDR_WIDTH-1:0] w_addr_next;

    logic [DATA_WIDTH-1:0]      w_head;
    logic                       w_empty;
    logic                       w_full;

    // r_active keeps pix_ready low through reset and its release edge.
    assign pix_ready = r_active && init_done && !w_full;
    assign w_accept  = pix_valid && pix_ready;
    assign w_slot    = frame_start ? '0 : r_cnt;
    assign w_last    = w_accept && !frame_start && (r_cnt == CNT_W'(PIX_PER_WORD - 1));

    always_comb begin
        w_word_ins = frame_start ? '0 : r_word;
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            if (w_slot == CNT_W'(k)) begin
                w_word_ins[k*PIX_W +: PIX_W] = pix_data;
            end
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (!rstn) begin
            r_active    <= 1'b0;
            r_cnt       <= '0;
            r_word      <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_active <= 1'b1;
            r_push   <= w_last;
            if (w_last) begin
                r_push_data <= w_word_ins;
                r_cnt       <= '0;
                r_word      <= '0;
            end else if (w_accept) begin
                r_cnt  <= w_slot + CNT_W'(1);
                r_word <= w_word_ins;
            end else if (frame_start) begin
                r_cnt  <= '0;
                r_word <= '0;
            end
        end
    end

    ddr_wr_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (ddr_clk),
        .rst_n       (rstn),
        .i_push      (r_push),
        .i_push_data (r_push_data),
        .i_pop       (w_pop),
        .o_head_c    (w_head),
        .o_empty_c   (w_empty),
        .o_full_c    (w_full),
        .o_level     (fifo_level)
    );

    always_ff @(posedge ddr_clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pending address reset is applied in IDLE before any new request launches.
    always_comb begin
        w_state_nxt = r_state;
        w_enter_req = 1'b0;
        w_pop       = 1'b0;
        w_addr_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_addr_rst_pend) begin
                    w_addr_clr = 1'b1;
                end else if (!w_empty && !wr_busy && init_done) begin
                    w_state_nxt = S_REQ;
                    w_enter_req = 1'b1;
                end
            end
            S_REQ: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wr_done) begin
                    w_state_nxt = S_IDLE;
                    w_pop       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_addr_next = (r_addr >= MAX_ADDR) ? '0 : r_addr + CTRL_ADDR_WIDTH'(ADDR_STEP);

    always_ff @(posedge ddr_clk) begin
        if (!rstn) begin
            r_wr_req        <= 1'b0;
            r_waddr         <= '0;
            r_wdata         <= '0;
            r_addr          <= '0;
            r_addr_rst_pend <= 1'b0;
        end else begin
            r_wr_req <= w_enter_req;
            if (w_enter_req) begin
                r_waddr <= r_addr;
                r_wdata <= w_head;
            end
            if (w_pop) begin
                r_addr <= w_addr_next;
            end else if (w_addr_clr) begin
                r_addr <= '0;
            end
            if (frame_start) begin
                r_addr_rst_pend <= 1'b1;
            end else if (w_addr_clr) begin
                r_addr_rst_pend <= 1'b0;
            end
        end
    end

    assign wr_req    = r_wr_req;
    assign ddr_waddr = r_waddr;
    assign ddr_wdata = r_wdata;
    assign awlen     = 4'd0;

endmodule

// File: tb/tb_ddr_frame_writer.sv
// Scoreboard bench for ddr_frame_writer: a pixel-level model predicts every
// DDR write; a controller model checks requests and answers with wr_done.
module tb_ddr_frame_writer;

    localparam int unsigned PPW   = 10;
    localparam int unsigned STEP  = 32;
    localparam logic [27:0] MAXA  = 28'h80;

    typedef struct packed {
        logic [27:0]  addr;
        logic [255:0] data;
    } wr_t;

    logic         ddr_clk = 1'b0;
    logic         rstn = 1'b0;
    logic         init_done = 1'b0;
    logic         frame_start = 1'b0;
    logic         pix_valid = 1'b0;
    logic [23:0]  pix_data = '0;
    logic         pix_ready;
    logic         wr_req;
    logic [27:0]  ddr_waddr;
    logic [3:0]   awlen;
    logic [255:0] ddr_wdata;
    logic         wr_busy = 1'b0;
    logic         wr_done = 1'b0;
    logic [4:0]   fifo_level;

    int  n_vec = 0;
    int  n_err = 0;
    int  n_req = 0;
    bit  hold_done = 1'b0;
    bit  busy_en = 1'b0;
    bit  no_req = 1'b0;
    bit  in_flight = 1'b0;
    logic [27:0] last_addr = '0;
    logic [27:0] prev_addr = '0;

    wr_t         exp_q[$];
    logic [23:0] part_q[$];
    logic [27:0] m_addr = '0;

    ddr_frame_writer #(
        .MAX_ADDR (MAXA)
    ) dut (
        .ddr_clk     (ddr_clk),
        .rstn        (rstn),
        .init_done   (init_done),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .wr_req      (wr_req),
        .ddr_waddr   (ddr_waddr),
        .awlen       (awlen),
        .ddr_wdata   (ddr_wdata),
        .wr_busy     (wr_busy),
        .wr_done     (wr_done),
        .fifo_level  (fifo_level)
    );

    always #5 ddr_clk = ~ddr_clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference model: ten pixels make a word, pixel k sits at bits 24k+.
    function automatic void model_accept(input logic [23:0] p);
        logic [255:0] d;
        part_q.push_back(p);
        if (part_q.size() == PPW) begin
            d = '0;
            for (int k = 0; k < PPW; k++) begin
                d = d | (256'(part_q[k]) << (24 * k));
            end
            exp_q.push_back('{addr: m_addr, data: d});
            m_addr = (m_addr == MAXA) ? 28'h0 : m_addr + 28'(STEP);
            part_q.delete();
        end
    endfunction

    function automatic void model_reset();
        part_q.delete();
        exp_q.delete();
        m_addr = '0;
    endfunction

    task automatic send_pix(input logic [23:0] p);
        int guard;
        guard = 0;
        pix_valid = 1'b1;
        pix_data  = p;
        #1;
        while (!pix_ready && guard < 4000) begin
            @(negedge ddr_clk);
            #1;
            guard++;
        end
        chk("pix_accept", pix_ready, 1'b1);
        if (pix_ready) model_accept(p);
        @(negedge ddr_clk);
        pix_valid = 1'b0;
    endtask

    task automatic do_frame_start(input bit with_pix, input logic [23:0] p);
        frame_start = 1'b1;
        part_q.delete();
        m_addr = '0;
        if (with_pix) begin
            pix_valid = 1'b1;
            pix_data  = p;
            #1;
            chk("fs_pix_ready", pix_ready, 1'b1);
            if (pix_ready) model_accept(p);
        end
        @(negedge ddr_clk);
        frame_start = 1'b0;
        pix_valid   = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || in_flight) && t < 5000) begin
            @(negedge ddr_clk);
            t++;
        end
        chk("drain_queue", 256'(exp_q.size()), 256'(0));
        repeat (2) @(negedge ddr_clk);
        chk("drain_level", fifo_level, 5'd0);
    endtask

    task automatic wait_in_flight();
        int t;
        t = 0;
        while (!in_flight && t < 3000) begin
            @(negedge ddr_clk);
            t++;
        end
        chk("req_seen", in_flight, 1'b1);
    endtask

    // Controller model / monitor: pops the scoreboard on each wr_req.
    initial begin : ctrl
        wr_t e;
        int  dly;
        bit  aborted;
        forever begin
            @(negedge ddr_clk);
            wr_busy = busy_en && ($urandom_range(3) == 0);
            if (!rstn || !wr_req) continue;
            n_req++;
            prev_addr = last_addr;
            last_addr = ddr_waddr;
            if (no_req) chk("req_while_init_low", wr_req, 1'b0);
            if (exp_q.size() == 0) begin
                chk("unexpected_wr_req", wr_req, 1'b0);
                continue;
            end
            in_flight = 1'b1;
            e = exp_q.pop_front();
            chk("waddr", ddr_waddr, e.addr);
            chk("wdata", ddr_wdata, e.data);
            chk("awlen", awlen, 4'd0);
            dly = $urandom_range(0, 4);
            aborted = 1'b0;
            do begin
                @(negedge ddr_clk);
                if (!rstn) begin
                    aborted = 1'b1;
                    break;
                end
                chk("wr_req_single", wr_req, 1'b0);
                chk("waddr_hold", ddr_waddr, e.addr);
                chk("wdata_hold", ddr_wdata, e.data);
                if (dly > 0) dly--;
            end while (dly > 0 || hold_done);
            if (!aborted) begin
                wr_done = 1'b1;
                @(negedge ddr_clk);
                wr_done = 1'b0;
            end
            in_flight = 1'b0;
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n0;

        // Reset values
        repeat (3) @(negedge ddr_clk);
        chk("rst_wr_req", wr_req, 1'b0);
        chk("rst_waddr", ddr_waddr, 28'h0);
        chk("rst_wdata", ddr_wdata, 256'h0);
        chk("rst_awlen", awlen, 4'd0);
        chk("rst_level", fifo_level, 5'd0);
        chk("rst_pix_ready", pix_ready, 1'b0);
        rstn = 1'b1;
        repeat (3) @(negedge ddr_clk);
        chk("ready_init_low", pix_ready, 1'b0);
        init_done = 1'b1;
        repeat (2) @(negedge ddr_clk);
        chk("ready_init_high", pix_ready, 1'b1);

        // Ten identical pixels -> one word at address 0
        for (int i = 0; i < 10; i++) send_pix(24'h144475);
        wait_drain();
        chk("first_word_addr", last_addr, 28'h0);

        // Three words from a fresh frame -> addresses 0, 32, 64
        do_frame_start(1'b0, 24'h0);
        n0 = n_req;
        for (int i = 0; i < 30; i++) send_pix(24'($urandom));
        wait_drain();
        chk("three_word_reqs", 256'(n_req - n0), 256'(3));
        chk("third_addr", last_addr, 28'd64);

        // Continue past MAX_ADDR -> 96, 128, then wrap to 0
        for (int i = 0; i < 30; i++) send_pix(24'($urandom));
        wait_drain();
        chk("wrap_prev_addr", prev_addr, MAXA);
        chk("wrap_next_addr", last_addr, 28'h0);

        // Partial word discarded by frame_start
        send_pix(24'h111111);
        wait_drain();
        for (int i = 0; i < 6; i++) send_pix(24'($urandom));
        do_frame_start(1'b0, 24'h0);
        n0 = n_req;
        for (int i = 0; i < 10; i++) send_pix(24'($urandom));
        wait_drain();
        chk("fs_one_word", 256'(n_req - n0), 256'(1));
        chk("fs_addr", last_addr, 28'h0);

        // Pixel accepted with frame_start becomes pixel 0
        for (int i = 0; i < 4; i++) send_pix(24'($urandom));
        do_frame_start(1'b1, 24'hABCDEF);
        for (int i = 0; i < 9; i++) send_pix(24'($urandom));
        wait_drain();

        // init_done falls during WAIT: write completes, nothing new issued
        hold_done = 1'b1;
        for (int i = 0; i < 20; i++) send_pix(24'($urandom));
        wait_in_flight();
        @(negedge ddr_clk);
        init_done = 1'b0;
        no_req    = 1'b1;
        hold_done = 1'b0;
        repeat (20) @(negedge ddr_clk);
        chk("init_low_done", in_flight, 1'b0);
        chk("init_low_level", fifo_level, 5'd1);
        chk("init_low_ready", pix_ready, 1'b0);
        no_req    = 1'b0;
        init_done = 1'b1;
        wait_drain();

        // Back-pressure: withhold wr_done until the FIFO fills
        hold_done = 1'b1;
        fork
            begin
                for (int i = 0; i < 170; i++) send_pix(24'($urandom));
            end
            begin
                int t;
                t = 0;
                while (fifo_level != 5'd16 && t < 3000) begin
                    @(negedge ddr_clk);
                    t++;
                end
                chk("full_level", fifo_level, 5'd16);
                repeat (3) @(negedge ddr_clk);
                chk("full_level_hold", fifo_level, 5'd16);
                chk("full_ready_low", pix_ready, 1'b0);
                hold_done = 1'b0;
            end
        join
        wait_drain();

        // Reset in the middle of a write
        hold_done = 1'b1;
        for (int i = 0; i < 15; i++) send_pix(24'($urandom));
        wait_in_flight();
        @(negedge ddr_clk);
        rstn = 1'b0;
        @(negedge ddr_clk);
        chk("mid_rst_wr_req", wr_req, 1'b0);
        chk("mid_rst_waddr", ddr_waddr, 28'h0);
        chk("mid_rst_wdata", ddr_wdata, 256'h0);
        chk("mid_rst_awlen", awlen, 4'd0);
        chk("mid_rst_level", fifo_level, 5'd0);
        chk("mid_rst_ready", pix_ready, 1'b0);
        model_reset();
        @(negedge ddr_clk);
        rstn = 1'b1;
        hold_done = 1'b0;
        repeat (2) @(negedge ddr_clk);
        for (int i = 0; i < 10; i++) send_pix(24'($urandom));
        wait_drain();
        chk("post_rst_addr", last_addr, 28'h0);

        // Randomized traffic with controller back-pressure
        busy_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 96) begin
                wait_drain();
                do_frame_start(1'($urandom_range(1)), 24'($urandom));
            end
            send_pix(24'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge ddr_clk);
        end
        busy_en = 1'b0;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
